// File: rtl/tone_mapping_ctrl_if.sv
// ---------------------------------------------------------------------------
// tone_mapping_ctrl_if
// Pixel stream plus configuration/statistics bundle for tone_mapping_ctrl.
//   master : drives the stream (sop/eop/valid/data) and enable, observes results
//   slave  : the controller; consumes the stream, drives cfg_* / frame_* / err_*
// ---------------------------------------------------------------------------
interface tone_mapping_ctrl_if #(
   parameter int W   = 10,
   parameter int SW  = 4,
   parameter int FCW = 16
);
   logic           sop;
   logic           eop;
   logic           valid;
   logic [W-1:0]   data [3];
   logic           enable;
   logic [SW-1:0]  cfg_shift;
   logic           cfg_upd;
   logic [W-1:0]   frame_max;
   logic           frame_done;
   logic [FCW-1:0] frame_cnt;
   logic           err_sop;
   logic           err_eop;

   modport master (
      output sop, eop, valid, data, enable,
      input  cfg_shift, cfg_upd, frame_max, frame_done, frame_cnt, err_sop, err_eop
   );

   modport slave (
      input  sop, eop, valid, data, enable,
      output cfg_shift, cfg_upd, frame_max, frame_done, frame_cnt, err_sop, err_eop
   );
endinterface

// File: rtl/tone_mapping_ctrl.sv
// ---------------------------------------------------------------------------
// tone_mapping_ctrl
// Frame-level controller for the tone-mapping datapath. Tracks the per-frame
// peak RGB component, derives a normalising left-shift at end of frame and
// applies it only at the next accepted sop so a frame never sees a change.
// Also flags framing errors and counts completed good frames.
//
// Ports:
//   clk    - system clock
//   reset  - asynchronous reset, active-high
//   bus    - tone_mapping_ctrl_if.slave:
//            in : sop, eop, valid, data[3], enable
//            out: cfg_shift, cfg_upd, frame_max, frame_done, frame_cnt,
//                 err_sop, err_eop
//
// Build option: define TM_IIR_EN to compute the shift from a smoothed peak
// (sm_max) instead of the raw per-frame peak.
// ---------------------------------------------------------------------------
module tone_mapping_ctrl #(
   parameter int W         = 10,
   parameter int SW        = 4,
   parameter int MAX_SHIFT = 7,
   parameter int FCW       = 16
) (
   input  logic               clk,
   input  logic               reset,
   tone_mapping_ctrl_if.slave bus
);
   localparam int LZW = $clog2(W + 1);

   typedef enum logic [1:0] {IDLE, ACTIVE, CALC} state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   acc_max_q, acc_max_d;
   logic           pending_q, pending_d;
   logic [SW-1:0]  pend_shift_q, pend_shift_d;
   logic [SW-1:0]  cfg_shift_q, cfg_shift_d;
   logic           cfg_upd_q, cfg_upd_d;
   logic [W-1:0]   frame_max_q, frame_max_d;
   logic           frame_done_q, frame_done_d;
   logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
   logic           err_sop_q, err_sop_d;
   logic           err_eop_q, err_eop_d;

   logic           v_sop, v_eop;
   logic [W-1:0]   pix_max, shift_src;
   logic [LZW-1:0] lz;
   logic [SW-1:0]  calc_shift;

   assign v_sop = bus.valid & bus.sop;
   assign v_eop = bus.valid & bus.eop;

   always_comb begin
      pix_max = bus.data[0];
      if (bus.data[1] > pix_max) pix_max = bus.data[1];
      if (bus.data[2] > pix_max) pix_max = bus.data[2];
   end

   // Leading zeros over W bits; the highest set bit is visited last and wins.
   function automatic logic [LZW-1:0] lzc(input logic [W-1:0] v);
      lzc = LZW'(W);
      for (int i = 0; i < W; i++)
         if (v[i]) lzc = LZW'(W - 1 - i);
   endfunction

`ifdef TM_IIR_EN
   logic [W-1:0] sm_max_q;
   logic         sm_vld_q;
   logic [W:0]   sm_sum;
   assign sm_sum    = {1'b0, sm_max_q} + {1'b0, acc_max_q};
   assign shift_src = sm_vld_q ? sm_sum[W:1] : acc_max_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sm_max_q <= '0;
         sm_vld_q <= 1'b0;
      end else if (state_q == CALC) begin
         sm_max_q <= shift_src;
         sm_vld_q <= 1'b1;
      end
   end
`else
   assign shift_src = acc_max_q;
`endif

   assign lz         = lzc(shift_src);
   assign calc_shift = (lz > LZW'(MAX_SHIFT)) ? SW'(MAX_SHIFT) : SW'(lz);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state. A sop seen in CALC is treated exactly like one seen in IDLE.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ACTIVE:  if (v_eop) state_d = CALC;
         default: begin
            if (v_sop) state_d = bus.eop ? CALC : ACTIVE;
            else       state_d = IDLE;
         end
      endcase
   end

   // Datapath / output next-state
   always_comb begin
      acc_max_d    = acc_max_q;
      pending_d    = pending_q;
      pend_shift_d = pend_shift_q;
      cfg_shift_d  = cfg_shift_q;
      frame_max_d  = frame_max_q;
      frame_cnt_d  = frame_cnt_q;
      frame_done_d = 1'b0;

      if (state_q == ACTIVE) begin
         // sop inside an open frame restarts accumulation (frame discarded)
         if (bus.valid)
            acc_max_d = (bus.sop || pix_max > acc_max_q) ? pix_max : acc_max_q;
      end else if (v_sop) begin
         acc_max_d = pix_max;
      end

      if (state_q == CALC) begin
         pend_shift_d = calc_shift;
         pending_d    = 1'b1;
         frame_max_d  = acc_max_q;
         frame_cnt_d  = frame_cnt_q + 1'b1;
         frame_done_d = 1'b1;
      end

      // Apply at sop; pending_d/pend_shift_d already carry a CALC-cycle result.
      if (v_sop) begin
         if (!bus.enable) begin
            cfg_shift_d = '0;
         end else if (pending_d) begin
            cfg_shift_d = pend_shift_d;
            pending_d   = 1'b0;
         end
      end

      cfg_upd_d = (cfg_shift_d != cfg_shift_q);
      err_sop_d = (state_q == ACTIVE) && v_sop;
      err_eop_d = (state_q != ACTIVE) && v_eop && !bus.sop;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_max_q    <= '0;
         pending_q    <= 1'b0;
         pend_shift_q <= '0;
         cfg_shift_q  <= '0;
         cfg_upd_q    <= 1'b0;
         frame_max_q  <= '0;
         frame_done_q <= 1'b0;
         frame_cnt_q  <= '0;
         err_sop_q    <= 1'b0;
         err_eop_q    <= 1'b0;
      end else begin
         acc_max_q    <= acc_max_d;
         pending_q    <= pending_d;
         pend_shift_q <= pend_shift_d;
         cfg_shift_q  <= cfg_shift_d;
         cfg_upd_q    <= cfg_upd_d;
         frame_max_q  <= frame_max_d;
         frame_done_q <= frame_done_d;
         frame_cnt_q  <= frame_cnt_d;
         err_sop_q    <= err_sop_d;
         err_eop_q    <= err_eop_d;
      end
   end

   assign bus.cfg_shift  = cfg_shift_q;
   assign bus.cfg_upd    = cfg_upd_q;
   assign bus.frame_max  = frame_max_q;
   assign bus.frame_done = frame_done_q;
   assign bus.frame_cnt  = frame_cnt_q;
   assign bus.err_sop    = err_sop_q;
   assign bus.err_eop    = err_eop_q;

endmodule

// File: tb/tb_tone_mapping_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tone_mapping_ctrl
// Directed bench for tone_mapping_ctrl (W=10, SW=4, MAX_SHIFT=7, FCW=16).
// Inputs change 1 time unit after a rising edge; outputs are checked there.
// ---------------------------------------------------------------------------
module tb_tone_mapping_ctrl;
   localparam int W = 10, SW = 4, MAX_SHIFT = 7, FCW = 16;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   tone_mapping_ctrl_if #(.W(W), .SW(SW), .FCW(FCW)) bus ();

   tone_mapping_ctrl #(.W(W), .SW(SW), .MAX_SHIFT(MAX_SHIFT), .FCW(FCW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
      $fatal(1, "watchdog");
   end

   // One stimulus cycle: drive, take one rising edge, settle 1 unit.
   task automatic beat(input logic v, input logic s, input logic e,
                       input logic [W-1:0] r, input logic [W-1:0] g, input logic [W-1:0] b);
      bus.valid   = v;
      bus.sop     = s;
      bus.eop     = e;
      bus.data[0] = r;
      bus.data[1] = g;
      bus.data[2] = b;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      beat(1'b0, 1'b1, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF); // ignored: valid=0
   endtask

   task automatic test_reset();
      bus.enable = 1'b1;
      bus.valid = 1'b0; bus.sop = 1'b0; bus.eop = 1'b0;
      bus.data[0] = '0; bus.data[1] = '0; bus.data[2] = '0;
      reset = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (bus.cfg_shift !== 4'd0) begin n_fail++; $display("FAIL rst_cfg_shift got %0d want 0", bus.cfg_shift); end
      n_checks++; if (bus.frame_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_frame_cnt got %0d want 0", bus.frame_cnt); end
      n_checks++; if ({bus.cfg_upd, bus.frame_done, bus.err_sop, bus.err_eop, bus.frame_max} !== 14'd0)
         begin n_fail++; $display("FAIL rst_misc got %h want 0", {bus.cfg_upd, bus.frame_done, bus.err_sop, bus.err_eop, bus.frame_max}); end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      beat(1, 1, 0, 10'h010, 10'h005, 10'h000);
      beat(1, 0, 0, 10'h000, 10'h0FF, 10'h010);
      beat(1, 0, 0, 10'h020, 10'h000, 10'h001);
      beat(1, 0, 1, 10'h001, 10'h000, 10'h000);
      n_checks++; if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL basic_done_early got %b want 0", bus.frame_done); end
      idle();
      n_checks++; if (bus.frame_done !== 1'b1) begin n_fail++; $display("FAIL basic_done got %b want 1", bus.frame_done); end
      n_checks++; if (bus.frame_max !== 10'h0FF) begin n_fail++; $display("FAIL basic_max got %h want 0ff", bus.frame_max); end
      n_checks++; if (bus.frame_cnt !== 16'd1) begin n_fail++; $display("FAIL basic_cnt got %0d want 1", bus.frame_cnt); end
      n_checks++; if (bus.cfg_shift !== 4'd0) begin n_fail++; $display("FAIL basic_shift_held got %0d want 0", bus.cfg_shift); end
      idle();
      n_checks++; if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got %b want 0", bus.frame_done); end
      beat(1, 1, 0, 10'h000, 10'h000, 10'h000);
      n_checks++; if (bus.cfg_shift !== 4'd2) begin n_fail++; $display("FAIL basic_apply got %0d want 2", bus.cfg_shift); end
      n_checks++; if (bus.cfg_upd !== 1'b1) begin n_fail++; $display("FAIL basic_upd got %b want 1", bus.cfg_upd); end
      beat(1, 0, 0, 10'h000, 10'h000, 10'h000);
      n_checks++; if (bus.cfg_upd !== 1'b0) begin n_fail++; $display("FAIL basic_upd_pulse got %b want 0", bus.cfg_upd); end
   endtask

   // Frame open on entry. Peaks 0x3FF, 0x003, 0x000 -> shifts 0, 7, 7.
   task automatic test_shifts();
      beat(1, 0, 1, 10'h3FF, 10'h000, 10'h000);
      idle();
      n_checks++; if (bus.frame_max !== 10'h3FF) begin n_fail++; $display("FAIL sh_max3ff got %h want 3ff", bus.frame_max); end
      n_checks++; if (bus.frame_cnt !== 16'd2) begin n_fail++; $display("FAIL sh_cnt2 got %0d want 2", bus.frame_cnt); end
      idle();
      beat(1, 1, 0, 10'h000, 10'h000, 10'h000);
      n_checks++; if (bus.cfg_shift !== 4'd0) begin n_fail++; $display("FAIL sh_full got %0d want 0", bus.cfg_shift); end
      n_checks++; if (bus.cfg_upd !== 1'b1) begin n_fail++; $display("FAIL sh_full_upd got %b want 1", bus.cfg_upd); end
      beat(1, 0, 1, 10'h000, 10'h003, 10'h002);
      idle();
      n_checks++; if (bus.frame_max !== 10'h003) begin n_fail++; $display("FAIL sh_max3 got %h want 003", bus.frame_max); end
      idle();
      beat(1, 1, 0, 10'h000, 10'h000, 10'h000);
      n_checks++; if (bus.cfg_shift !== 4'd7) begin n_fail++; $display("FAIL sh_clamp got %0d want 7", bus.cfg_shift); end
      beat(1, 0, 1, 10'h000, 10'h000, 10'h000);
      idle();
      n_checks++; if (bus.frame_cnt !== 16'd4) begin n_fail++; $display("FAIL sh_cnt4 got %0d want 4", bus.frame_cnt); end
      idle();
      beat(1, 1, 0, 10'h000, 10'h000, 10'h000);
      n_checks++; if (bus.cfg_shift !== 4'd7) begin n_fail++; $display("FAIL sh_zero got %0d want 7", bus.cfg_shift); end
      n_checks++; if (bus.cfg_upd !== 1'b0) begin n_fail++; $display("FAIL sh_zero_noupd got %b want 0", bus.cfg_upd); end
   endtask

   // Frame open on entry.
   task automatic test_errors();
      beat(1, 0, 0, 10'h100, 10'h000, 10'h000);
      beat(0, 0, 1, 10'h000, 10'h000, 10'h000);
      n_checks++; if (bus.err_eop !== 1'b0) begin n_fail++; $display("FAIL err_eop_novalid got %b want 0", bus.err_eop); end
      beat(1, 1, 0, 10'h040, 10'h000, 10'h000);
      n_checks++; if (bus.err_sop !== 1'b1) begin n_fail++; $display("FAIL err_sop got %b want 1", bus.err_sop); end
      beat(1, 0, 0, 10'h010, 10'h000, 10'h000);
      n_checks++; if (bus.err_sop !== 1'b0) begin n_fail++; $display("FAIL err_sop_pulse got %b want 0", bus.err_sop); end
      n_checks++; if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL err_no_done got %b want 0", bus.frame_done); end
      beat(1, 0, 1, 10'h008, 10'h000, 10'h000);
      idle();
      n_checks++; if (bus.frame_max !== 10'h040) begin n_fail++; $display("FAIL err_newmax got %h want 040", bus.frame_max); end
      n_checks++; if (bus.frame_cnt !== 16'd5) begin n_fail++; $display("FAIL err_cnt got %0d want 5", bus.frame_cnt); end
      idle();
      beat(1, 0, 1, 10'h3FF, 10'h000, 10'h000);
      n_checks++; if (bus.err_eop !== 1'b1) begin n_fail++; $display("FAIL err_eop got %b want 1", bus.err_eop); end
      idle();
      n_checks++; if (bus.err_eop !== 1'b0) begin n_fail++; $display("FAIL err_eop_pulse got %b want 0", bus.err_eop); end
      n_checks++; if (bus.frame_cnt !== 16'd5) begin n_fail++; $display("FAIL err_eop_cnt got %0d want 5", bus.frame_cnt); end
   endtask

   // Idle on entry with pending shift 3 (peak 0x040).
   task automatic test_enable();
      bus.enable = 1'b0;
      beat(1, 1, 0, 10'h000, 10'h000, 10'h000);
      n_checks++; if (bus.cfg_shift !== 4'd0) begin n_fail++; $display("FAIL en0_shift got %0d want 0", bus.cfg_shift); end
      n_checks++; if (bus.cfg_upd !== 1'b1) begin n_fail++; $display("FAIL en0_upd got %b want 1", bus.cfg_upd); end
      beat(1, 0, 1, 10'h000, 10'h080, 10'h000);
      idle();
      n_checks++; if (bus.frame_max !== 10'h080) begin n_fail++; $display("FAIL en0_stats got %h want 080", bus.frame_max); end
      bus.enable = 1'b1;
      idle();
      beat(1, 1, 0, 10'h000, 10'h000, 10'h000);
      n_checks++; if (bus.cfg_shift !== 4'd2) begin n_fail++; $display("FAIL en1_shift got %0d want 2", bus.cfg_shift); end
   endtask

   // Frame open on entry, cfg_shift=2, frame_cnt=6.
   task automatic test_back_to_back();
      beat(1, 0, 1, 10'h3FF, 10'h000, 10'h000);
      beat(1, 1, 1, 10'h000, 10'h000, 10'h080);
      n_checks++; if (bus.cfg_shift !== 4'd0) begin n_fail++; $display("FAIL b2b_fresh got %0d want 0", bus.cfg_shift); end
      n_checks++; if (bus.frame_done !== 1'b1) begin n_fail++; $display("FAIL b2b_done1 got %b want 1", bus.frame_done); end
      n_checks++; if (bus.frame_cnt !== 16'd7) begin n_fail++; $display("FAIL b2b_cnt7 got %0d want 7", bus.frame_cnt); end
      idle();
      n_checks++; if (bus.frame_max !== 10'h080) begin n_fail++; $display("FAIL b2b_1pix got %h want 080", bus.frame_max); end
      n_checks++; if (bus.frame_cnt !== 16'd8) begin n_fail++; $display("FAIL b2b_cnt8 got %0d want 8", bus.frame_cnt); end
      idle();
      beat(1, 1, 0, 10'h000, 10'h000, 10'h000);
      n_checks++; if (bus.cfg_shift !== 4'd2) begin n_fail++; $display("FAIL b2b_1pix_shift got %0d want 2", bus.cfg_shift); end
   endtask

   // Frame open on entry, cfg_shift=2, frame_cnt=8.
   task automatic test_reset_mid();
      beat(1, 0, 0, 10'h3FF, 10'h000, 10'h000);
      #3 reset = 1'b1;
      #1;
      n_checks++; if ({bus.cfg_shift, bus.frame_cnt, bus.frame_max} !== 30'd0)
         begin n_fail++; $display("FAIL rmid_clear got %h want 0", {bus.cfg_shift, bus.frame_cnt, bus.frame_max}); end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      beat(1, 0, 0, 10'h3FF, 10'h000, 10'h000);
      beat(1, 0, 1, 10'h3FF, 10'h000, 10'h000);
      n_checks++; if (bus.err_eop !== 1'b1) begin n_fail++; $display("FAIL rmid_err_eop got %b want 1", bus.err_eop); end
      idle();
      n_checks++; if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL rmid_no_done got %b want 0", bus.frame_done); end
      n_checks++; if (bus.frame_cnt !== 16'd0) begin n_fail++; $display("FAIL rmid_cnt got %0d want 0", bus.frame_cnt); end
   endtask

   // Peaks 0x3FF then 0x0FF. Smoothed: 0x3FF, 0x27F -> shift 0; raw: shift 2.
   task automatic test_iir();
      logic [SW-1:0] exp_sh;
`ifdef TM_IIR_EN
      exp_sh = 4'd0;
`else
      exp_sh = 4'd2;
`endif
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      idle();
      beat(1, 1, 0, 10'h3FF, 10'h000, 10'h000);
      beat(1, 0, 1, 10'h000, 10'h000, 10'h000);
      idle();
      idle();
      beat(1, 1, 0, 10'h000, 10'h0FF, 10'h000);
      n_checks++; if (bus.cfg_shift !== 4'd0) begin n_fail++; $display("FAIL iir_shift1 got %0d want 0", bus.cfg_shift); end
      beat(1, 0, 1, 10'h000, 10'h000, 10'h000);
      idle();
      n_checks++; if (bus.frame_max !== 10'h0FF) begin n_fail++; $display("FAIL iir_rawmax got %h want 0ff", bus.frame_max); end
      idle();
      beat(1, 1, 0, 10'h000, 10'h000, 10'h000);
      n_checks++; if (bus.cfg_shift !== exp_sh) begin n_fail++; $display("FAIL iir_shift2 got %0d want %0d", bus.cfg_shift, exp_sh); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_shifts();
      test_errors();
      test_enable();
      test_back_to_back();
      test_reset_mid();
      test_iir();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/tone_mapping_ctrl.md
Name: tone_mapping_ctrl

Overview:
Frame-level controller for the per-channel tone-mapping datapath. Monitors the same RGB pixel stream (sop/eop/valid, data[3]) that feeds the datapath and tracks the per-frame peak component value. At end of frame it derives a normalising left-shift. It applies that shift to the datapath configuration only at the next accepted start of frame, so a frame never sees a mid-frame change. Also flags framing errors and counts completed frames.

Parameters:
W, 10, pixel component width (matches datapath input width)
SW, 4, width of cfg_shift output
MAX_SHIFT, 7, upper clamp for computed shift (must be < 2**SW and <= W)
FCW, 16, width of frame counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-high
sop  in  1  start of frame, qualified by valid
eop  in  1  end of frame, qualified by valid
valid  in  1  pixel beat strobe
data  in  3 x W  R,G,B components (unpacked array [3])
enable  in  1  1 = adaptive shift; 0 = force shift 0 from next frame
cfg_shift  out  SW  shift applied by datapath; stable for a whole frame
cfg_upd  out  1  one-cycle pulse: cfg_shift just changed
frame_max  out  W  peak component of last good frame
frame_done  out  1  one-cycle pulse: frame_max/frame_cnt updated
frame_cnt  out  FCW  completed good frames, wraps
err_sop  out  1  pulse: sop inside open frame
err_eop  out  1  pulse: eop with no open frame

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; acc_max=0, pending=0, pend_shift=0.
- Only beats with valid=1 are considered; sop/eop/data ignored when valid=0.
- pix_max = max(data[0],data[1],data[2]), combinational.
- States: IDLE, ACTIVE, CALC.
- IDLE: valid&sop -> acc_max<=pix_max, go ACTIVE. If valid&sop&eop on the same beat (1-pixel frame), go CALC. valid&eop without sop -> err_eop pulse next cycle, stay IDLE.
- ACTIVE: valid -> acc_max<=max(acc_max,pix_max). valid&eop -> CALC.
- ACTIVE, valid&sop -> err_sop pulse. Current frame discarded (no CALC, no count), acc_max<=pix_max, stay ACTIVE. If that beat also has eop, go CALC with the new frame.
- CALC (1 cycle):
  - lz = leading zeros of acc_max over W bits; acc_max=0 gives lz=W.
  - pend_shift<=min(lz,MAX_SHIFT); pending<=1.
  - frame_max<=acc_max; frame_cnt<=frame_cnt+1 (wraps at 2**FCW); frame_done=1 for one cycle.
  - If valid&sop arrives in CALC, it is accepted: the IDLE-sop rules apply and the next state is ACTIVE/CALC. The apply rule below uses the pend_shift just computed.
- Latency: eop beat sampled at edge E0. frame_done, frame_max and frame_cnt are visible after E1.
- Apply rule: at the edge where a valid&sop beat is accepted (any state):
  - If enable=1 and pending=1: cfg_shift<=pend_shift and pending<=0.
  - If enable=0: cfg_shift<=0.
  - cfg_upd pulses in the following cycle only if the value changed.
  - cfg_shift never changes at any other edge.
- enable does not affect accumulation or statistics.
- First frame after reset runs with cfg_shift=0.
- A discarded frame (err_sop) does not clear pending.
- Reset mid-frame: everything returns to reset values immediately. The rest of the interrupted frame is ignored until the next sop; a stray eop produces err_eop.

Optional Feature:
TM_IIR_EN: when defined, CALC computes the shift from sm_max instead of acc_max.
- sm_max<=(sm_max+acc_max)>>1, using a W+1-bit sum.
- First good frame after reset loads sm_max<=acc_max directly.
- frame_max still reports raw acc_max.
When undefined, there is no sm_max register and the shift comes directly from acc_max.

Test Plan:
- Reset, then frame sop..eop of 4 beats, peaks 0x010,0x0FF,0x020,0x001 -> frame_max=0x0FF, shift computes 2, frame_cnt=1, cfg_shift still 0; next sop -> cfg_shift=2, cfg_upd pulse.
- Frames with peak 0x3FF, 0x003, 0x000 (MAX_SHIFT=7) -> shifts 0, 7 (clamped from 8), 7 (zero case), each applied at following sop.
- sop at beat 3 of open frame -> err_sop pulse, first frame not counted, frame_cnt unchanged, new frame accumulates from beat 3; eop with no sop -> err_eop pulse.
- Back-to-back: sop on cycle right after eop (CALC) -> accepted, cfg_shift takes freshly computed value at that sop; single-beat sop&eop frame, peak 0x080 -> shift 2.
- enable=0 with pending shift 3 -> next sop sets cfg_shift=0; enable=1 again -> next good frame's shift applied; reset asserted mid-frame -> all outputs 0 immediately.
- TM_IIR_EN: frames with peaks 0x3FF then 0x0FF -> sm_max 0x3FF then 0x27F, shifts 0 then 0 (raw frame_max 0x0FF).
